// File: rtl/edge_frame_compositor.sv
// edge_frame_compositor
// Raster-scans an IMG_W x IMG_H frame after the Sobel stage finishes. It merges
// the bbox edge BRAM (inside the bounding box) and the background edge BRAM
// (everywhere else) into one thresholded pixel stream, and counts edge pixels.
//
// Ports:
//   clka, reset          clock, asynchronous active-high reset
//   start                one-cycle frame start pulse (honoured only in IDLE)
//   thr_bg, thr_bb       background / bbox thresholds, latched on start
//   bg_en/bg_addr/bg_dout  background BRAM port (1-cycle read latency)
//   bb_en/bb_addr/bb_dout  bbox BRAM port (1-cycle read latency)
//   pix_data/pix_valid/pix_ready/pix_last  output pixel stream
//   busy, done           frame in progress / one-cycle completion pulse
//   edge_count           edge pixels handshaken in the current/last frame
module edge_frame_compositor #(
    parameter int IMG_W      = 256,
    parameter int IMG_H      = 256,
    parameter int BBOX_X0    = 106,
    parameter int BBOX_Y0    = 127,
    parameter int BBOX_X1    = 189,
    parameter int BBOX_Y1    = 169,
    parameter int BINARIZE   = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clka,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  thr_bg,
    input  logic [7:0]  thr_bb,
    output logic        bg_en,
    output logic [15:0] bg_addr,
    input  logic [7:0]  bg_dout,
    output logic        bb_en,
    output logic [15:0] bb_addr,
    input  logic [7:0]  bb_dout,
    output logic [7:0]  pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_last,
    output logic        busy,
    output logic        done,
    output logic [16:0] edge_count
);

    localparam int BBW = BBOX_X1 - BBOX_X0 + 1;
    localparam int CW  = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t        state_r;
    logic [15:0]   row_r, col_r;
    logic [7:0]    thr_bg_r, thr_bb_r;
    logic          bg_en_r, bb_en_r, busy_r, done_r;
    logic [15:0]   bg_addr_r, bb_addr_r;
    logic [16:0]   edge_count_r;

    // Tag pipe: stage 1 lines up with the BRAM address, stage 2 with its data.
    logic          v1_r, reg1_r, bord1_r, last1_r;
    logic          v2_r, reg2_r, bord2_r, last2_r;

    // FIFO entry layout: {last, edge, pixel}
    logic [9:0]    mem_r [FIFO_DEPTH];
    logic [CW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW:0]   count_r;
    logic          pix_valid_r;

    logic          in_box_s, border_s, last_pix_s, credit_s, issue_s, hs_s;
    logic [CW+1:0] occ_s;
    logic [15:0]   bg_addr_s, bb_addr_s;
    logic [7:0]    val_s, thr_s, pdata_s;
    logic          edge_s;
    logic [9:0]    head_s;
    logic [CW:0]   count_nxt_s;

    assign in_box_s   = (row_r >= 16'(BBOX_Y0)) && (row_r <= 16'(BBOX_Y1)) &&
                        (col_r >= 16'(BBOX_X0)) && (col_r <= 16'(BBOX_X1));
    assign border_s   = (row_r == 16'd0) || (col_r == 16'd0);
    assign last_pix_s = (row_r == 16'(IMG_H - 1)) && (col_r == 16'(IMG_W - 1));
    assign bg_addr_s  = row_r * 16'(IMG_W) + col_r;
    assign bb_addr_s  = (row_r - 16'(BBOX_Y0)) * 16'(BBW) + (col_r - 16'(BBOX_X0));

    // Credit counts reads still in the tag pipe so the FIFO can never overflow.
    assign occ_s    = (CW+2)'(count_r) + (CW+2)'(v1_r) + (CW+2)'(v2_r);
    assign credit_s = occ_s < (CW+2)'(FIFO_DEPTH);
    assign issue_s  = (state_r == RUN) && credit_s;

    // Border pixels never had a BRAM read; their value is forced to zero.
    assign val_s   = bord2_r ? 8'h00 : (reg2_r ? bb_dout : bg_dout);
    assign thr_s   = reg2_r ? thr_bb_r : thr_bg_r;
    assign edge_s  = val_s >= thr_s;
    assign pdata_s = (BINARIZE != 0) ? {8{edge_s}} : val_s;

    assign head_s = mem_r[rd_ptr_r];
    assign hs_s   = pix_valid_r && pix_ready;

    // Occupancy after this cycle's write (stage 2 valid) and read (handshake).
    always_comb begin
        count_nxt_s = count_r;
        case ({v2_r, hs_s})
            2'b10:   count_nxt_s = count_r + (CW+1)'(1);
            2'b01:   count_nxt_s = count_r - (CW+1)'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Frame FSM, scan position, BRAM address issue, tag pipe and edge counter.
    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            row_r        <= 16'd0;
            col_r        <= 16'd0;
            thr_bg_r     <= 8'h00;
            thr_bb_r     <= 8'h00;
            bg_en_r      <= 1'b0;
            bb_en_r      <= 1'b0;
            bg_addr_r    <= 16'd0;
            bb_addr_r    <= 16'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            edge_count_r <= 17'd0;
            v1_r         <= 1'b0;
            reg1_r       <= 1'b0;
            bord1_r      <= 1'b0;
            last1_r      <= 1'b0;
            v2_r         <= 1'b0;
            reg2_r       <= 1'b0;
            bord2_r      <= 1'b0;
            last2_r      <= 1'b0;
        end else begin
            bg_en_r <= 1'b0;
            bb_en_r <= 1'b0;
            done_r  <= 1'b0;
            v1_r    <= issue_s;
            reg1_r  <= in_box_s;
            bord1_r <= border_s;
            last1_r <= last_pix_s;
            v2_r    <= v1_r;
            reg2_r  <= reg1_r;
            bord2_r <= bord1_r;
            last2_r <= last1_r;

            if ((state_r == IDLE) && start) begin
                edge_count_r <= 17'd0;
            end else if (hs_s && head_s[8]) begin
                edge_count_r <= edge_count_r + 17'd1;
            end else begin
                edge_count_r <= edge_count_r;
            end

            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r  <= RUN;
                        busy_r   <= 1'b1;
                        thr_bg_r <= thr_bg;
                        thr_bb_r <= thr_bb;
                        row_r    <= 16'd0;
                        col_r    <= 16'd0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (issue_s) begin
                        if (border_s) begin
                            bg_en_r <= 1'b0;
                        end else if (in_box_s) begin
                            bb_en_r   <= 1'b1;
                            bb_addr_r <= bb_addr_s;
                        end else begin
                            bg_en_r   <= 1'b1;
                            bg_addr_r <= bg_addr_s;
                        end
                        if (col_r == 16'(IMG_W - 1)) begin
                            col_r <= 16'd0;
                            row_r <= row_r + 16'd1;
                        end else begin
                            col_r <= col_r + 16'd1;
                        end
                        if (last_pix_s) begin
                            state_r <= DRAIN;
                        end else begin
                            state_r <= RUN;
                        end
                    end else begin
                        state_r <= RUN;
                    end
                end
                DRAIN: begin
                    // The last token is the final FIFO entry, so its handshake
                    // also means the FIFO is empty.
                    if (hs_s && head_s[9]) begin
                        state_r <= FIN;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                FIN: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Output FIFO; the head entry drives the stream directly.
    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 10'd0;
            end
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            pix_valid_r <= 1'b0;
        end else begin
            if (v2_r) begin
                mem_r[wr_ptr_r] <= {last2_r, edge_s, pdata_s};
                wr_ptr_r        <= wr_ptr_r + CW'(1);
            end
            if (hs_s) begin
                rd_ptr_r <= rd_ptr_r + CW'(1);
            end
            count_r     <= count_nxt_s;
            pix_valid_r <= count_nxt_s != '0;
        end
    end

    assign bg_en      = bg_en_r;
    assign bb_en      = bb_en_r;
    assign bg_addr    = bg_addr_r;
    assign bb_addr    = bb_addr_r;
    assign pix_valid  = pix_valid_r;
    assign pix_data   = head_s[7:0];
    assign pix_last   = head_s[9] & pix_valid_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign edge_count = edge_count_r;

endmodule

// File: doc/edge_frame_compositor.md
# edge_frame_compositor

Downstream consumer of the Sobel edge stage. After the Sobel stage signals `done`, this block raster-scans the full 256×256 frame and merges the two edge memories into one pixel stream: bounding-box pixels come from the bbox edge BRAM, all other pixels come from the background edge BRAM. Each pixel is thresholded with a per-region threshold and sent out on a valid/ready stream, and edge pixels are counted. The stream feeds the frame writer / host DMA.

## Interface

Parameters:
- `IMG_W`, default 256: frame width in pixels.
- `IMG_H`, default 256: frame height in pixels.
- `BBOX_X0`, default 106: bbox left column, inclusive.
- `BBOX_Y0`, default 127: bbox top row, inclusive.
- `BBOX_X1`, default 189: bbox right column, inclusive.
- `BBOX_Y1`, default 169: bbox bottom row, inclusive.
- `BINARIZE`, default 1: 1 = output 8'hFF/8'h00; 0 = pass the raw magnitude through.
- `FIFO_DEPTH`, default 4: output FIFO entries, power of 2, ≥4.

Ports:
- `clka`  in  1: clock.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle pulse that begins a frame; driven by the Sobel `done`.
- `thr_bg`  in  8: background threshold; sampled on `start`.
- `thr_bb`  in  8: bbox threshold; sampled on `start`.
- `bg_en`  out  1: background BRAM enable.
- `bg_addr`  out  16: background BRAM address, row*IMG_W+col.
- `bg_dout`  in  8: background BRAM read data, 1-cycle read latency.
- `bb_en`  out  1: bbox BRAM enable.
- `bb_addr`  out  16: bbox BRAM address, (row−BBOX_Y0)*BBW+(col−BBOX_X0), where BBW = BBOX_X1−BBOX_X0+1 = 84.
- `bb_dout`  in  8: bbox BRAM read data, 1-cycle read latency.
- `pix_data`  out  8: output pixel.
- `pix_valid`  out  1: output valid.
- `pix_ready`  in  1: downstream ready.
- `pix_last`  out  1: high with the final pixel of the frame, (IMG_H−1, IMG_W−1).
- `busy`  out  1: high from the `start` edge until `done`.
- `done`  out  1: one-cycle pulse after the last pixel is accepted.
- `edge_count`  out  17: number of thresholded edge pixels in the frame; held until the next `start`.

## Operation

- FSM states and transitions:
  - IDLE → RUN on `start`.
  - RUN → DRAIN once the last address has been issued.
  - DRAIN → FIN once the FIFO is empty and the last pixel has been handshaken.
  - FIN → IDLE. FIN lasts one cycle and pulses `done`.
- `start` is ignored unless the FSM is in IDLE.
- On accepted `start`:
  - Clear `edge_count`.
  - Latch the two thresholds.
  - Set the scan position to row = col = 0.
- Address issue happens in RUN, one pixel per cycle, when FIFO occupancy + in-flight reads < FIFO_DEPTH.
  - Pixel inside the bbox (inclusive bounds): drive `bb_en` = 1 and `bb_addr`; `bg_en` = 0.
  - Pixel outside the bbox: drive `bg_en` = 1 and `bg_addr`; `bb_en` = 0.
  - Border pixel (row 0 or col 0): the Sobel stage never writes these, so no BRAM read is issued. The token still travels the read pipeline with a forced value of 8'h00, so pixel order is preserved.
  - No issue in a cycle: both enables are 0 and the addresses hold.
- Scan order: col increments first; it wraps IMG_W−1 → 0 and row then increments. The token for (IMG_H−1, IMG_W−1) carries the last flag.
- Read pipeline: a 2-stage tag pipe carries {region, border, last} alongside each read. Data is captured from the selected `*_dout` 2 edges after issue and written into the FIFO.
- Output value per pixel:
  - thr = region ? thr_bb : thr_bg.
  - edge = (v ≥ thr), unsigned 8-bit compare.
  - `pix_data` = BINARIZE ? {8{edge}} : v.
  - Border pixels have v = 0. If thr = 0, a border pixel therefore counts as an edge.
- `edge_count` increments by 1 on each handshake (`pix_valid` && `pix_ready`) of an edge pixel. Maximum value 65536, so 17 bits do not overflow.
- Reset mid-frame: all state is cleared asynchronously. In-flight data is discarded and no `done` is produced.

## Timing

- Reset values:
  - `bg_en` = `bb_en` = 0, `bg_addr` = `bb_addr` = 0.
  - `pix_valid` = `pix_last` = 0, `pix_data` = 0.
  - `busy` = `done` = 0, `edge_count` = 0.
  - FSM in IDLE, FIFO empty.
- Latency:
  - `start` sampled at edge 0 → first address driven after edge 1.
  - BRAM output valid after edge 2 → FIFO write at edge 3.
  - `pix_valid` first high after edge 3.
- Throughput: 1 pixel/cycle while `pix_ready` is held at 1. A full frame takes 65536 + 4 cycles from `start` to `done`.
- Handshake rules:
  - `pix_data` and `pix_last` are stable while `pix_valid` && !`pix_ready`.
  - `pix_valid` never drops without a handshake.
  - `pix_ready` may toggle every cycle. The issue credit guarantees that the FIFO never overflows.
- Simultaneous FIFO write and read: occupancy is unchanged, and the FIFO stays valid at depth FIFO_DEPTH.
- `done` pulses in the cycle after the handshake of the `pix_last` beat. `busy` falls in the same cycle that `done` is high.

## Test plan

- Full frame, `pix_ready` = 1, BRAMs preloaded with addr[7:0], thresholds 0x80:
  - Exactly 65536 beats; `pix_last` on beat 65535 only.
  - `done` one cycle later; `edge_count` equals the model count.
- Region mapping: bbox BRAM holds 0xAA and background BRAM holds 0x55, with BINARIZE = 0:
  - Pixel (127,106) reads bb addr 0 → 0xAA.
  - Pixel (169,189) reads bb addr 3611 → 0xAA.
  - Pixels (126,106) and (127,190) read background → 0x55.
- Borders: all BRAM locations 0xFF, thresholds 0x01:
  - Every row-0 and col-0 pixel outputs 0x00 with no BRAM enable asserted.
  - `edge_count` = 65536 − 511 = 65025.
- Threshold edge, background 0x40: thr_bg = 0x40 → 0xFF and counted; thr_bg = 0x41 → 0x00 and not counted.
- Random `pix_ready` (30% duty) over a full frame:
  - Data and last stay stable under stall; no beats lost or duplicated.
  - Output order matches raster order.
- `reset` asserted at beat 1000:
  - All outputs return to their reset values immediately; no `done`.
  - A following `start` produces a complete, correct frame.
- `start` pulsed again while `busy`: ignored; the frame completes normally.
